// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative RV32M multiply/divide unit with its EX-stage sequencer.
//            Accepts one M-extension op, runs a shift-add multiply or a
//            restoring divide over XLEN cycles, and stalls the pipeline until
//            the result is ready. Divide-by-zero and signed overflow finish
//            in one cycle.
// Ports    : clk, reset (sync, active-high)
//            start, funct3, op_a, op_b : op request from EX (sampled in IDLE)
//            flush                     : squash any in-flight op
//            stall                     : hold IF/ID/EX
//            done                      : one-cycle result-valid pulse
//            result                    : registered result, held until next op
// Revision : 1.0  initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CNT_W  = $clog2(XLEN);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  c_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_hi;      // product high half / partial remainder
    logic [XLEN-1:0] r_lo;      // multiplier bits / dividend shifting into quotient
    logic [XLEN-1:0] r_b;       // |op_b|: multiplicand or divisor
    logic            r_neg_q;   // negate product / quotient
    logic            r_neg_r;   // negate remainder
    logic [XLEN-1:0] r_result;

    // ---------------- operand decode at accept ----------------
    logic            w_accept;
    logic            w_a_signed, w_b_signed, w_sa, w_sb;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_div0, w_ovf, w_fast;
    logic [XLEN-1:0] w_fast_res;

    assign w_accept   = (r_state == S_IDLE) && start && !flush;
    // MULH, MULHSU, DIV, REM treat op_a as signed; MULH, DIV, REM treat op_b as signed
    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_sa       = w_a_signed && op_a[XLEN-1];
    assign w_sb       = w_b_signed && op_b[XLEN-1];
    assign w_mag_a    = w_sa ? (~op_a + 1'b1) : op_a;
    assign w_mag_b    = w_sb ? (~op_b + 1'b1) : op_b;

    assign w_div0     = funct3[2] && (op_b == '0);
    assign w_ovf      = funct3[2] && !funct3[0] && (op_a == c_MIN) && (op_b == c_ONES);
    assign w_fast     = w_div0 || w_ovf;
    // funct3[1] selects remainder over quotient
    assign w_fast_res = w_div0 ? (funct3[1] ? op_a : c_ONES)
                               : (funct3[1] ? '0   : c_MIN);

    // ---------------- one iteration of the datapath ----------------
    logic [XLEN:0]   w_sum, w_shift, w_diff;
    logic            w_fits;
    logic [XLEN-1:0] w_hi_nxt, w_lo_nxt;

    // multiply: add multiplicand on the current multiplier bit, then shift right
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    // divide: shift next dividend bit into remainder, subtract if it fits
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_fits  = !w_diff[XLEN];

    always_comb begin
        if (r_f3[2]) begin
            w_hi_nxt = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_fits};
        end else begin
            w_hi_nxt = w_sum[XLEN:1];
            w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // ---------------- final sign fix-up ----------------
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_quo, w_rem, w_final;

    assign w_prod   = {w_hi_nxt, w_lo_nxt};
    assign w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quo    = r_neg_q ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
    assign w_rem    = r_neg_r ? (~w_hi_nxt + 1'b1) : w_hi_nxt;

    always_comb begin
        if (r_f3[2])
            w_final = r_f3[1] ? w_rem : w_quo;
        else if (r_f3[1:0] == 2'b00)
            w_final = w_prod_s[XLEN-1:0];
        else
            w_final = w_prod_s[2*XLEN-1:XLEN];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset || flush)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stall       = 1'b1;
                    w_state_nxt = w_fast ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                stall = 1'b1;
                if (r_cnt == c_LAST)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // a squash or reset this cycle suppresses both handshake outputs
        if (reset || flush) begin
            stall = 1'b0;
            done  = 1'b0;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_cnt    <= '0;
            r_f3     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_f3    <= funct3;
                        r_hi    <= '0;
                        r_lo    <= w_mag_a;
                        r_b     <= w_mag_b;
                        r_cnt   <= '0;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        if (w_fast)
                            r_result <= w_fast_res;
                    end
                end
                S_RUN: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST)
                        r_result <= w_final;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Scoreboard bench for muldiv_sequencer. Stimulus pushes the
//            expected result and completion cycle; a monitor pops and
//            compares on every done pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, start, flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a, op_b;
    logic            stall, done;
    logic [XLEN-1:0] result;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        int          at;
        logic [2:0]  f;
    } exp_t;

    exp_t sbq[$];
    exp_t m_e;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain 64-bit arithmetic on the architectural rules
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'b000: begin p = 64'(ua * ub); return p[31:0];  end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub); return p[63:32]; end
            3'b011: begin p = 64'(ua * ub); return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'b110: return (b == 0) ? a : 32'(sa % sb);
            default: return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    // cycles from the start cycle to the done cycle
    function automatic int latency(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if (f[2] && !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_done: got result %h expected no done", result);
            end else begin
                m_e = sbq.pop_front();
                n_cmp++;
                if (result !== m_e.res) begin
                    n_fail++;
                    $display("FAIL result f3=%0d: got %h expected %h", m_e.f, result, m_e.res);
                end
                n_cmp++;
                if (cyc != m_e.at) begin
                    n_fail++;
                    $display("FAIL done_cycle f3=%0d: got %0d expected %0d", m_e.f, cyc, m_e.at);
                end
            end
        end
    end

    // Drive one start cycle; optionally register the expectation
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        if (push) sbq.push_back('{model(f, a, b), cyc + latency(f, a, b), f});
        @(negedge clk);
        check("stall_on_start", 32'(stall), 32'd1);
        @(posedge clk); #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
    endtask

    // Count stall cycles up to done; optionally hold start through the DONE cycle
    task automatic wait_done(input int exp_stall, input bit hold);
        int cnt = 1;
        int k   = 0;
        while (k < 100) begin
            @(negedge clk);
            if (done) break;
            if (stall) cnt++;
            k++;
        end
        if (k >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected within 100 cycles");
            return;
        end
        check("stall_at_done", 32'(stall), 32'd0);
        check("stall_cycles", 32'(cnt), 32'(exp_stall));
        if (hold) begin
            start  = 1'b1;
            funct3 = 3'b000;
            op_a   = 32'd3;
            op_b   = 32'd5;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            check("start_in_done_ignored", 32'({stall, done}), 32'd0);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit hold);
        issue(f, a, b, 1'b1);
        wait_done(latency(f, a, b), hold);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {29'b0, stall, done, 1'b0}, 32'd0);
        check("reset_result", result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // directed cases
        run_op(3'b000, 32'd7, 32'd6, 1'b0);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'b101, 32'd100, 32'd7, 1'b0);
        run_op(3'b111, 32'd100, 32'd7, 1'b0);
        run_op(3'b101, 32'd5, 32'd0, 1'b1);
        run_op(3'b110, 32'd5, 32'd0, 1'b0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // start together with flush in IDLE is not accepted
        @(posedge clk); #1;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("start_with_flush_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("start_with_flush_idle", 32'({stall, done}), 32'd0);

        // flush mid-RUN: no done, stall low, result cleared, next op accepted
        issue(3'b000, 32'd7, 32'd6, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_cycle_outputs", 32'({stall, done}), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("after_flush_outputs", 32'({stall, done}), 32'd0);
        check("after_flush_result", result, 32'd0);
        run_op(3'b000, 32'd123, 32'd456, 1'b0);

        // reset mid-RUN
        issue(3'b101, 32'd1000, 32'd3, 1'b0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("after_reset_outputs", 32'({stall, done}), 32'd0);
        check("after_reset_result", result, 32'd0);

        // randomized ops
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom);
            a = pick();
            b = pick();
            run_op(f, a, b, 1'($urandom));
        end

        repeat (5) @(posedge clk);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
